ex_div: RTL and testbench

Multi-cycle 32-bit integer divider in the EX stage, serving the DIV/DIVU ALU operations. It reads the operation and operands that the ID/EX pipeline register presents to EX and raises a stall request toward the pipeline controller. That request holds the ID/EX register and all earlier stages until the quotient and remainder are ready. It implements a radix-2 restoring algorithm (one quotient bit per clock) with sign pre- and post-correction for signed division.

---
 rtl/ex_div.sv | 111 +++++++++++
 tb/tb_ex_div.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_div.sv
// rtl/ex_div.sv - radix-2 restoring 32-bit divider for DIV/DIVU in EX
// Holds the pipeline through stall_req_o until {remainder, quotient} is ready.
module ex_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        stall_req_o
);

  typedef enum logic [1:0] {ST_FREE, ST_BY_ZERO, ST_ON, ST_END} state_t;

  state_t      r_state;
  logic [5:0]  r_cnt;
  logic [64:0] r_work;
  logic [31:0] r_divisor;
  logic        r_signed;
  logic        r_neg1;
  logic        r_neg2;

  logic [31:0] w_abs1;
  logic [31:0] w_abs2;
  logic [33:0] w_diff;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  assign w_abs1 = (signed_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
  assign w_abs2 = (signed_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

  // Upper 34 bits of the shifted working register; the top bit is always 0
  // because the partial remainder stays below the divisor.
  assign w_diff = r_work[64:31] - {2'b00, r_divisor};

  assign w_quot = (r_signed && (r_neg1 ^ r_neg2)) ? (~r_work[31:0] + 32'd1) : r_work[31:0];
  assign w_rem  = (r_signed && r_neg1) ? (~r_work[63:32] + 32'd1) : r_work[63:32];

  assign stall_req_o = start_i & ~ready_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_FREE;
      r_cnt     <= 6'd0;
      r_work    <= 65'd0;
      r_divisor <= 32'd0;
      r_signed  <= 1'b0;
      r_neg1    <= 1'b0;
      r_neg2    <= 1'b0;
      result_o  <= 64'd0;
      ready_o   <= 1'b0;
    end else begin
      case (r_state)
        ST_FREE: begin
          ready_o  <= 1'b0;
          result_o <= 64'd0;
          if (start_i && !annul_i) begin
            if (opdata2_i == 32'd0) begin
              r_state <= ST_BY_ZERO;
            end else begin
              r_state   <= ST_ON;
              r_work    <= {33'd0, w_abs1};
              r_cnt     <= 6'd0;
              r_divisor <= w_abs2;
              r_signed  <= signed_i;
              r_neg1    <= opdata1_i[31];
              r_neg2    <= opdata2_i[31];
            end
          end
        end
        ST_BY_ZERO: begin
          if (annul_i || !start_i) begin
            r_state <= ST_FREE;
          end else begin
            r_state  <= ST_END;
            result_o <= 64'd0;
            ready_o  <= 1'b1;
          end
        end
        ST_ON: begin
          if (annul_i || !start_i) begin
            r_state <= ST_FREE;
          end else if (r_cnt != 6'd32) begin
            if (!w_diff[33]) begin
              r_work <= {w_diff[32:0], r_work[30:0], 1'b1};
            end else begin
              r_work <= {r_work[63:0], 1'b0};
            end
            r_cnt <= r_cnt + 6'd1;
          end else begin
            r_state  <= ST_END;
            result_o <= {w_rem, w_quot};
            ready_o  <= 1'b1;
          end
        end
        ST_END: begin
          if (annul_i || !start_i) begin
            r_state  <= ST_FREE;
            ready_o  <= 1'b0;
            result_o <= 64'd0;
          end
        end
        default: r_state <= ST_FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_div.sv
// tb/tb_ex_div.sv - scoreboard bench for ex_div with a plain-arithmetic reference model
module tb_ex_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stall_req_o;

  always #5 clk = ~clk;

  ex_div dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .signed_i   (signed_i),
    .opdata1_i  (opdata1_i),
    .opdata2_i  (opdata2_i),
    .annul_i    (annul_i),
    .result_o   (result_o),
    .ready_o    (ready_o),
    .stall_req_o(stall_req_o)
  );

  typedef struct {
    logic [63:0] res;
    int          lat;
    int          t0;
  } exp_t;

  exp_t        sb_q[$];
  int          checks    = 0;
  int          failures  = 0;
  int          cyc       = 0;
  int          stall_cnt = 0;
  logic [63:0] held      = 64'd0;
  logic        prev_ready = 1'b0;
  logic        start_s    = 1'b0;
  logic        annul_s    = 1'b0;
  logic        rst_s      = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: language arithmetic, with the one overflowing signed case pinned.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    int sa;
    int sb;
    int q;
    int r;
    if (b == 32'd0) return 64'd0;
    if (!s) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    sa = $signed(a);
    sb = $signed(b);
    q  = sa / sb;
    r  = sa % sb;
    return {r, q};
  endfunction

  // Monitor: pops the scoreboard whenever ready_o rises.
  always @(negedge clk) begin
    exp_t e;
    if (start_i && !ready_o) stall_cnt++;
    else if (!start_i) stall_cnt = 0;
    if (ready_o && !prev_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_ready", {63'd0, ready_o}, 64'd0);
      end else begin
        e = sb_q.pop_front();
        chk("result", result_o, e.res);
        chk("latency", 64'(cyc - e.t0), 64'(e.lat));
        chk("stall_cycles", 64'(stall_cnt), 64'(e.lat));
        held = e.res;
      end
    end else if (ready_o && prev_ready) begin
      chk("result_held", result_o, held);
    end
    if (ready_o === 1'b0) chk("result_zero_when_idle", result_o, 64'd0);
    if (prev_ready && start_s && !annul_s && !rst_s) chk("ready_held", {63'd0, ready_o}, 64'd1);
    prev_ready = ready_o;
    start_s    = start_i;
    annul_s    = annul_i;
    rst_s      = rst;
  end

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input int hold, input bit chg);
    exp_t e;
    int   n;
    @(posedge clk);
    #1;
    opdata1_i = a;
    opdata2_i = b;
    signed_i  = s;
    start_i   = 1'b1;
    e.res = ref_div(a, b, s);
    e.lat = (b == 32'd0) ? 2 : 34;
    e.t0  = cyc;
    sb_q.push_back(e);
    if (chg && b != 32'd0) begin
      repeat (4) @(posedge clk);
      #1;
      opdata1_i = $urandom;
      opdata2_i = $urandom;
    end
    n = 0;
    @(negedge clk);
    while (!ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout actual=0 expected=1 a=%0h b=%0h", a, b);
      sb_q.delete();
    end
    repeat (hold) @(posedge clk);
    @(posedge clk);
    #1;
    start_i   = 1'b0;
    opdata1_i = $urandom;
    opdata2_i = $urandom;
  endtask

  // mode 0: annul pulse, 1: start dropped, 2: reset pulse; applied at edge E<at>.
  task automatic run_abort(input int mode, input int at);
    @(posedge clk);
    #1;
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    signed_i  = 1'b0;
    start_i   = 1'b1;
    repeat (at) @(posedge clk);
    #1;
    case (mode)
      0:       annul_i = 1'b1;
      1:       start_i = 1'b0;
      default: begin rst = 1'b1; start_i = 1'b0; end
    endcase
    @(posedge clk);
    #1;
    annul_i = 1'b0;
    rst     = 1'b0;
    start_i = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    rst       = 1'b1;
    start_i   = 1'b0;
    signed_i  = 1'b0;
    annul_i   = 1'b0;
    opdata1_i = 32'd0;
    opdata2_i = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", {63'd0, ready_o}, 64'd0);
    chk("reset_result", result_o, 64'd0);
    chk("reset_stall_low", {63'd0, stall_req_o}, 64'd0);
    start_i = 1'b1;
    #1;
    chk("reset_stall_follows_start", {63'd0, stall_req_o}, 64'd1);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    rst     = 1'b0;
    repeat (2) @(posedge clk);

    run_div(32'd100, 32'd7, 1'b0, 0, 1'b0);
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 0, 1'b0);
    run_div(32'd7, 32'hFFFF_FFFE, 1'b1, 0, 1'b0);
    run_div(32'hFFFF_FFFF, 32'd2, 1'b0, 0, 1'b0);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 1'b0);
    run_div(32'd1234, 32'd0, 1'b0, 0, 1'b0);
    run_div(32'hDEAD_BEEF, 32'd0, 1'b1, 0, 1'b0);
    run_div(32'd100, 32'd7, 1'b0, 5, 1'b0);
    run_div(32'h8765_4321, 32'd13, 1'b1, 0, 1'b1);

    run_abort(0, 10);
    run_div(32'd100, 32'd7, 1'b0, 0, 1'b0);
    run_abort(1, 20);
    run_div(32'd100, 32'd7, 1'b0, 0, 1'b0);
    run_abort(2, 15);
    run_div(32'd100, 32'd7, 1'b0, 0, 1'b0);

    @(posedge clk);
    #1;
    start_i = 1'b1;
    annul_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    annul_i = 1'b0;
    repeat (3) @(posedge clk);

    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFF_FFFF;
        3:       b = a;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      if (b == 32'd0 && $urandom_range(0, 1) == 1) b = 32'd3;
      run_div(a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    repeat (5) @(posedge clk);
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
